// File: rtl/fs_mult.sv
// Control FSM for the SPI multiplier: synchronises cs/sclk, counts operand and result bits,
// strobes the multiplier and enables MISO. States: WAIT idle | LOAD shift in | MULT start | MULTRES wait done | MISORESULT shift out
module fs_mult #(
  parameter int LOAD_BITS   = 8,
  parameter int RESULT_BITS = 8,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk,
  input  logic       done,
  output logic [1:0] mode,
  output logic       start,
  output logic       misobuffCNTL,
  output logic [2:0] actualstate
);

  typedef enum logic [2:0] {
    S_WAIT       = 3'd0,
    S_LOAD       = 3'd1,
    S_MULT       = 3'd2,
    S_MULTRES    = 3'd3,
    S_MISORESULT = 3'd4
  } state_t;

  localparam logic [CNT_W:0] LOAD_N = (CNT_W + 1)'(LOAD_BITS);
  localparam logic [CNT_W:0] RES_N  = (CNT_W + 1)'(RESULT_BITS);
  localparam logic [CNT_W:0] ONE    = (CNT_W + 1)'(1);

  state_t           state_q, state_d;
  logic             cs_s1_q, cs_s2_q;
  logic             sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
  logic [CNT_W:0]   cnt_inc;
  logic             done_seen_q, done_seen_d;
  logic             start_q, start_d;
  logic             sclk_rise, sclk_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s1_q     <= 1'b0;
      cs_s2_q     <= 1'b0;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_s1_q     <= cs;
      cs_s2_q     <= cs_s1_q;
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s2_q & sclk_prev_q;

  // Extra bit detects the terminal count and lets the stored count saturate instead of wrapping
  assign cnt_inc = {1'b0, cnt_q} + ONE;
  assign cnt_sat = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_seen_d = done_seen_q;
    case (state_q)
      S_WAIT: begin
        if (cs_s2_q) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (sclk_rise) begin
          if (cnt_inc == LOAD_N) begin
            state_d     = S_MULT;
            cnt_d       = '0;
            done_seen_d = 1'b0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end
      S_MULT: begin
        if (done) done_seen_d = 1'b1;
        if (sclk_rise) state_d = S_MULTRES;
      end
      S_MULTRES: begin
        if (done) done_seen_d = 1'b1;
        if (sclk_rise && (done_seen_q || done)) begin
          state_d = S_MISORESULT;
          cnt_d   = '0;
        end
      end
      S_MISORESULT: begin
        if (sclk_fall) begin
          if (cnt_inc == RES_N) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase
    // Losing chip select aborts from anywhere and swallows any coincident sclk edge
    if ((state_q != S_WAIT) && !cs_s2_q) begin
      state_d = S_WAIT;
      cnt_d   = '0;
    end
  end

  assign start_d = (state_d == S_MULT) && (state_q != S_MULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      done_seen_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_seen_q <= done_seen_d;
      start_q     <= start_d;
    end
  end

  always_comb begin
    mode         = 2'b00;
    misobuffCNTL = 1'b0;
    case (state_q)
      S_LOAD:       mode = 2'b01;
      S_MULTRES:    mode = 2'b10;
      S_MISORESULT: begin
        mode         = 2'b11;
        misobuffCNTL = 1'b1;
      end
      default:      mode = 2'b00;
    endcase
  end

  assign start       = start_q;
  assign actualstate = state_q;

endmodule

// File: tb/tb_fs_mult.sv
// Self-checking bench for fs_mult: expected state sequence is queued as stimulus is driven
// and matched against each observed state change.
module tb_fs_mult;

  logic       clk = 1'b0;
  logic       reset, cs, sclk, done;
  logic [1:0] mode;
  logic       start, misobuffCNTL;
  logic [2:0] actualstate;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  logic [2:0] prev_st = 3'd0;
  bit mon_en = 1'b0;
  int start_run = 0;
  int start_pulses = 0;

  fs_mult #(.LOAD_BITS(8), .RESULT_BITS(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .done(done),
    .mode(mode), .start(start), .misobuffCNTL(misobuffCNTL), .actualstate(actualstate)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int mode_of(input int st);
    case (st)
      1: return 1;
      3: return 2;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (start) start_run++;
      else if (start_run != 0) begin
        chk("start_width", start_run, 1);
        start_pulses++;
        start_run = 0;
      end
      if (actualstate != prev_st) begin
        if (exp_q.size() == 0) chk("unexpected_state", int'(actualstate), 8);
        else chk("state_seq", int'(actualstate), exp_q.pop_front());
        chk("mode_decode", int'(mode), mode_of(int'(actualstate)));
        chk("miso_decode", int'(misobuffCNTL), (actualstate == 3'd4) ? 1 : 0);
        prev_st = actualstate;
      end
    end
  end

  task automatic sclk_cycle();
    sclk = 1'b1;
    #200;
    sclk = 1'b0;
    #200;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cs = 1'b0; sclk = 1'b0; done = 1'b0;
    #53;
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    chk("rst_state", int'(actualstate), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_miso", int'(misobuffCNTL), 0);
    repeat (3) sclk_cycle();
    chk("wait_idle", int'(actualstate), 0);

    // Full transaction; cs stays high so WAIT re-enters LOAD right after the result
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(1);
    sclk = 1'b1; #100; cs = 1'b1; #100; sclk = 1'b0;
    chk("enter_load", int'(actualstate), 1);
    chk("load_mode", int'(mode), 1);
    #200;
    repeat (7) sclk_cycle();
    chk("load_7", int'(actualstate), 1);
    sclk_cycle();
    chk("load_8_mult", int'(actualstate), 2);
    chk("mult_mode", int'(mode), 0);
    chk("start_once", start_pulses, 1);
    sclk_cycle();
    chk("multres", int'(actualstate), 3);
    chk("multres_mode", int'(mode), 2);
    repeat (3) sclk_cycle();
    chk("multres_hold", int'(actualstate), 3);
    pulse_done();
    sclk_cycle();
    chk("misoresult", int'(actualstate), 4);
    chk("miso_en", int'(misobuffCNTL), 1);
    chk("miso_mode", int'(mode), 3);
    repeat (6) sclk_cycle();
    chk("miso_7falls", int'(actualstate), 4);
    sclk_cycle();
    chk("result_done_reload", int'(actualstate), 1);
    exp_q.push_back(0);
    cs = 1'b0;
    clks(5);
    chk("cs_drop_idle", int'(actualstate), 0);
    chk("idle_miso", int'(misobuffCNTL), 0);

    // cs drop mid-LOAD, then restart counts from zero
    exp_q.push_back(1);
    cs = 1'b1;
    clks(5);
    repeat (3) sclk_cycle();
    chk("load_3", int'(actualstate), 1);
    exp_q.push_back(0);
    @(posedge clk); #1 cs = 1'b0;
    clks(4);
    chk("cs_drop_load", int'(actualstate), 0);
    chk("cs_drop_mode", int'(mode), 0);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
    cs = 1'b1;
    clks(5);
    repeat (7) sclk_cycle();
    chk("restart_7", int'(actualstate), 1);
    sclk_cycle();
    chk("restart_8", int'(actualstate), 2);
    cs = 1'b0;
    clks(5);
    chk("restart_abort", int'(actualstate), 0);

    // done during MULT is remembered; reset during MISORESULT
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(0);
    cs = 1'b1;
    clks(5);
    repeat (8) sclk_cycle();
    chk("tx4_mult", int'(actualstate), 2);
    pulse_done();
    sclk_cycle();
    chk("tx4_multres", int'(actualstate), 3);
    sclk_cycle();
    chk("done_seen_miso", int'(actualstate), 4);
    #40;
    reset = 1'b1;
    #1;
    chk("rst_mid_state", int'(actualstate), 0);
    chk("rst_mid_mode", int'(mode), 0);
    chk("rst_mid_miso", int'(misobuffCNTL), 0);
    chk("rst_mid_start", int'(start), 0);
    cs = 1'b0;
    #40;
    reset = 1'b0;
    clks(6);
    chk("post_reset_wait", int'(actualstate), 0);
    chk("start_pulses", start_pulses, 3);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fs_mult.md
Name: fs_mult

Overview:
- Control FSM for the SPI multiplier peripheral.
- Runs in the fast system clock domain and samples the slow SPI clock (sclk) and an active-high chip select (cs).
- Sequences the transaction: operand shift-in, multiply start, result capture, result shift-out on MISO.
- Drives the operand/result shift-register mode, the multiplier start strobe and the MISO tri-state buffer enable.

Parameters:
- LOAD_BITS, 8: number of sclk rising edges spent shifting operands in (LOAD state).
- RESULT_BITS, 8: number of sclk falling edges spent shifting the result out (MISORESULT state).
- CNT_W, 4: width of the internal bit counter; must satisfy 2^CNT_W >= max(LOAD_BITS, RESULT_BITS).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  chip select, active-high; asynchronous to clk.
- sclk  input  1  SPI clock, asynchronous to clk and at least 8x slower.
- done  input  1  multiplier result valid, synchronous to clk.
- mode  output  2  shift-register control: 00 hold, 01 serial-in, 10 parallel-load, 11 serial-out.
- start  output  1  multiplier start strobe, one clk wide.
- misobuffCNTL  output  1  MISO tri-state enable, 1 = drive.
- actualstate  output  3  current state encoding, for debug and verification.

Behaviour:
- Synchronisation:
  - cs and sclk each pass through a 2-flop synchroniser.
  - sclk rise/fall are one-clk pulses derived from the synchronised value vs its previous sample.
- State encoding: WAIT=0, LOAD=1, MULT=2, MULTRES=3, MISORESULT=4. Codes 5-7 are illegal and go to WAIT on the next clk.
- Reset (async): state=WAIT, counter=0, done_seen=0, mode=00, start=0, misobuffCNTL=0.
- Outputs by state:
  - mode and misobuffCNTL are a Moore decode of the state.
  - start is registered.
  - WAIT: mode=00, start=0, misobuffCNTL=0.
  - LOAD: mode=01.
  - MULT: mode=00.
  - MULTRES: mode=10.
  - MISORESULT: mode=11, misobuffCNTL=1.
- WAIT -> LOAD: on the first clk where synchronised cs=1. Counter cleared.
- LOAD:
  - Each sclk rise increments the counter.
  - On the rise that makes count = LOAD_BITS: -> MULT, counter cleared.
- MULT:
  - start=1 for exactly the first clk in MULT; done_seen cleared on entry.
  - On the next sclk rise: -> MULTRES.
- MULTRES:
  - done_seen is set by done=1 in MULT or MULTRES.
  - On an sclk rise with done_seen=1, or done=1 in that same clk: -> MISORESULT, counter cleared.
  - Otherwise stays in MULTRES.
- MISORESULT:
  - Each sclk fall increments the counter.
  - On the fall that makes count = RESULT_BITS: -> WAIT.
- cs deassert: synchronised cs=0 in any non-WAIT state -> WAIT on the next clk, counter cleared. This has priority over all other transitions.
- Simultaneous sclk edge and cs drop: cs drop wins, no count.
- Counter saturates; it never wraps mid-state.
- Reset mid-transaction: immediate return to WAIT with all outputs 0.
- Latency: a state change follows the raw sclk/cs edge by 3-4 clk (sync + edge detect + state register).

Test Plan:
- Reset with cs=0, sclk idle -> actualstate=0, mode=00, start=0, misobuffCNTL=0; stays in WAIT with sclk toggling and cs=0.
- Raise cs after an sclk posedge -> actualstate=1 (LOAD), mode=01 by the following sclk negedge (clk period 20 ns, sclk period 400 ns).
- Stay in LOAD through exactly 8 sclk rises -> actualstate=2 (MULT) after the 8th; start high for exactly one clk; mode=00.
- Next sclk rise -> actualstate=3 (MULTRES), mode=10.
  - With done held 0: remains in MULTRES indefinitely.
  - Pulse done for one clk: MISORESULT (4) at the next sclk rise.
- In MISORESULT: misobuffCNTL=1, mode=11 -> after 8 sclk falls returns to WAIT with misobuffCNTL=0.
- Drop cs during LOAD after 3 bits, and separately assert reset during MISORESULT -> WAIT within 4 clk (cs drop) / immediately (reset), outputs 0. Re-raising cs restarts the LOAD count from 0.
